// File: rtl/frame_writer_pkg.sv
// Shared types and defaults for the frame writer: FSM encoding, address width
// and default frame/burst geometry.
package frame_writer_pkg;

  localparam int ADDR_W          = 24;
  localparam int DEF_FRAME_WORDS = 153600;
  localparam int DEF_BURST_LEN   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } fw_state_e;

endpackage

// File: rtl/frame_writer_fifo.sv
// Synchronous first-word-fall-through word FIFO with occupancy count and flush.
// A push while full is accepted when a pop happens in the same cycle.
module frame_writer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/frame_writer.sv
// Packs RGB565 pixel pairs into 32-bit words and writes them to memory in bursts.
// Define FRAME_WRITER_DOUBLE_BUF_EN to alternate between two frame buffers.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int BASE_ADDR0  = 0,
  parameter int BASE_ADDR1  = 153600,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [15:0]       pix_data,
  output logic              burst_req,
  output logic [ADDR_W-1:0] burst_addr,
  input  logic              burst_gnt,
  output logic              wr_valid,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              disp_buf
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  fw_state_e         state_q, state_d;
  logic [ADDR_W-1:0] offset_q, offset_d, offset_inc, base_addr;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [15:0]       lo_q, lo_d;
  logic              half_q, half_d, pending_q, pending_d, overflow_q, overflow_d;
  logic              pop, last_beat, wrap, clear, pix_take, word_done, fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       fifo_head;

  frame_writer_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .push      (word_done),
    .push_data ({pix_data, lo_q}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // A frame restart seen mid-burst is deferred and applied once back in IDLE.
  assign clear      = (state_q == ST_IDLE) && (frame_start || pending_q);
  assign pix_take   = pix_valid && !frame_start && !pending_q;
  assign word_done  = pix_take && half_q;
  assign pop        = (state_q == ST_DATA) && wr_ready;
  assign last_beat  = pop && (beat_q == BEAT_W'(BURST_LEN - 1));
  assign offset_inc = offset_q + ADDR_W'(BURST_LEN);
  assign wrap       = (offset_inc == ADDR_W'(FRAME_WORDS));

  assign burst_req  = (state_q == ST_REQ);
  assign burst_addr = base_addr + offset_q;
  assign wr_valid   = (state_q == ST_DATA);
  assign wr_data    = wr_valid ? fifo_head : 32'h0;
  assign frame_done = last_beat && wrap;
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    beat_d     = beat_q;
    lo_d       = lo_q;
    half_d     = half_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (pix_take) begin
      if (!half_q) lo_d = pix_data;
      half_d = !half_q;
    end
    if (word_done && fifo_full && !pop) overflow_d = 1'b1;
    if (frame_start && (state_q != ST_IDLE)) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          half_d     = 1'b0;
          offset_d   = '0;
          overflow_d = 1'b0;
          pending_d  = 1'b0;
        end else if (fifo_count >= CNT_W'(BURST_LEN)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (burst_gnt) begin
          state_d = ST_DATA;
          beat_d  = '0;
        end
      end
      ST_DATA: begin
        if (pop) beat_d = beat_q + BEAT_W'(1);
        if (last_beat) begin
          state_d  = ST_IDLE;
          beat_d   = '0;
          offset_d = wrap ? '0 : offset_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      offset_q   <= '0;
      beat_q     <= '0;
      lo_q       <= '0;
      half_q     <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      beat_q     <= beat_d;
      lo_q       <= lo_d;
      half_q     <= half_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FRAME_WRITER_DOUBLE_BUF_EN
  logic base_sel_q, base_sel_d, disp_q, disp_d;

  always_comb begin
    base_sel_d = base_sel_q;
    disp_d     = disp_q;
    if (frame_done) begin
      base_sel_d = !base_sel_q;
      disp_d     = base_sel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_sel_q <= 1'b0;
      disp_q     <= 1'b0;
    end else begin
      base_sel_q <= base_sel_d;
      disp_q     <= disp_d;
    end
  end

  assign base_addr = base_sel_q ? ADDR_W'(BASE_ADDR1) : ADDR_W'(BASE_ADDR0);
  assign disp_buf  = disp_q;
`else
  assign base_addr = ADDR_W'(BASE_ADDR0);
  assign disp_buf  = 1'b0;
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: directed scenarios plus a randomized
// stream, all checked against a word/burst-level reference model.
`timescale 1ns/1ps
module tb_frame_writer;

  localparam int FW    = 16;
  localparam int BL    = 8;
  localparam int DEPTH = 16;
  localparam int B0    = 0;
  localparam int B1    = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = 16'h0;
  logic        burst_gnt = 1'b0;
  logic        wr_ready = 1'b0;
  logic        burst_req, wr_valid, frame_done, overflow, disp_buf;
  logic [23:0] burst_addr;
  logic [31:0] wr_data;

  frame_writer #(
    .BASE_ADDR0 (B0),
    .BASE_ADDR1 (B1),
    .FRAME_WORDS(FW),
    .BURST_LEN  (BL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .burst_req  (burst_req),
    .burst_addr (burst_addr),
    .burst_gnt  (burst_gnt),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .frame_done (frame_done),
    .overflow   (overflow),
    .disp_buf   (disp_buf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory-side responder state
  typedef struct {
    logic [31:0] data;
    logic        fd;
    int          cyc;
  } beat_t;
  beat_t       beats_q[$];
  logic [23:0] gnt_addr_q[$];
  int          gnt_delay = 2;
  bit          gnt_en = 1'b1;
  int          rdy_mode = 0;
  int          cyc = 0;
  int          req_wait = 0;
  bit          stall_seen = 1'b0;
  logic [31:0] stall_data = 32'h0;

  // Reference model: expected words in order, plus frame/buffer bookkeeping
  logic [31:0] exp_q[$];
  bit          m_half = 1'b0;
  logic [15:0] m_lo = 16'h0;
  int          m_off = 0;
  bit          m_sel = 1'b0;
  bit          m_disp = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_limit = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelPixel(input logic [15:0] px);
    if (!m_half) begin
      m_lo   = px;
      m_half = 1'b1;
    end else begin
      m_half = 1'b0;
      if (m_limit && exp_q.size() >= DEPTH) m_ovf = 1'b1;
      else exp_q.push_back({px, m_lo});
    end
  endtask

  task automatic applyStimulus(input logic [15:0] px, input int gap);
    pix_valid = 1'b1;
    pix_data  = px;
    modelPixel(px);
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulseFrameStart();
    frame_start = 1'b1;
    m_half = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic waitBeats(input int n);
    int waited = 0;
    while (beats_q.size() < n && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
  endtask

  function automatic logic [23:0] modelAddr();
    return 24'((m_sel ? B1 : B0) + m_off);
  endfunction

  task automatic checkBursts(input int n, input string tag);
    beat_t       bt;
    logic [31:0] ew;
    logic [23:0] ga;
    bit          wrap;
    waitBeats(n * BL);
    checkOutput({tag, "_beat_count"}, 32'(beats_q.size() >= n * BL), 32'd1);
    if (beats_q.size() < n * BL) return;
    for (int b = 0; b < n; b++) begin
      wrap = (m_off + BL == FW);
      ga = (gnt_addr_q.size() > 0) ? gnt_addr_q.pop_front() : 24'hxxxxxx;
      checkOutput({tag, "_addr"}, {8'h0, ga}, {8'h0, modelAddr()});
      for (int i = 0; i < BL; i++) begin
        bt = beats_q.pop_front();
        ew = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checkOutput({tag, "_data"}, bt.data, ew);
        checkOutput({tag, "_frame_done"}, {31'h0, bt.fd}, {31'h0, (wrap && i == BL - 1)});
      end
      m_off = wrap ? 0 : m_off + BL;
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
      if (wrap) begin
        m_disp = m_sel;
        m_sel  = !m_sel;
      end
`endif
    end
  endtask

  // Memory-side responder: grants after a delay, drives wr_ready, records beats
  initial begin
    beat_t tmp;
    forever begin
      @(negedge clk);
      cyc++;
      case (rdy_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = !wr_ready;
        default: wr_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (burst_req && gnt_en && !rst) begin
        if (req_wait >= gnt_delay) begin
          burst_gnt = 1'b1;
          gnt_addr_q.push_back(burst_addr);
          req_wait = 0;
        end else begin
          burst_gnt = 1'b0;
          req_wait++;
        end
      end else begin
        burst_gnt = 1'b0;
        req_wait = 0;
      end
      #1;
      if (wr_valid && wr_ready) begin
        if (stall_seen) checkOutput("stall_hold", wr_data, stall_data);
        stall_seen = 1'b0;
        tmp.data = wr_data;
        tmp.fd   = frame_done;
        tmp.cyc  = cyc;
        beats_q.push_back(tmp);
      end else if (wr_valid) begin
        stall_seen = 1'b1;
        stall_data = wr_data;
      end
    end
  end

  initial begin
    int reqs;
    int span;
    repeat (3) @(negedge clk);
    checkOutput("rst_burst_req", {31'h0, burst_req}, 32'h0);
    checkOutput("rst_burst_addr", {8'h0, burst_addr}, 32'(B0));
    checkOutput("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
    checkOutput("rst_wr_data", wr_data, 32'h0);
    checkOutput("rst_frame_done", {31'h0, frame_done}, 32'h0);
    checkOutput("rst_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("rst_disp_buf", {31'h0, disp_buf}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic burst of 16 ramp pixels");
    gnt_delay = 2; gnt_en = 1'b1; rdy_mode = 0;
    for (int i = 1; i <= 16; i++) applyStimulus(16'(i), 0);
    waitBeats(BL);
    span = (beats_q.size() >= BL) ? beats_q[BL-1].cyc - beats_q[0].cyc : -1;
    checkOutput("ramp_consecutive", 32'(span), 32'(BL - 1));
    checkOutput("ramp_beat0", (beats_q.size() > 0) ? beats_q[0].data : 32'hx, 32'h0002_0001);
    checkOutput("ramp_beat7", (beats_q.size() >= BL) ? beats_q[BL-1].data : 32'hx, 32'h0010_000F);
    checkBursts(1, "ramp");

    $display("[TB] stalled burst with toggling wr_ready, ends the frame");
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) applyStimulus(16'($urandom), 0);
    checkBursts(1, "stall");
    repeat (10) @(negedge clk);
    checkOutput("stall_no_extra", 32'(beats_q.size()), 32'h0);
    checkOutput("frame1_disp_buf", {31'h0, disp_buf}, {31'h0, m_disp});

    $display("[TB] first burst of the next frame");
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) applyStimulus(16'($urandom), 0);
    checkBursts(1, "frame2");

    $display("[TB] grant withheld, FIFO overflow");
    repeat (3) @(negedge clk);
    pulseFrameStart();
    m_off = 0; m_ovf = 1'b0;
    gnt_en = 1'b0; m_limit = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus(16'($urandom), 0);
    m_limit = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("ovf_set", {31'h0, overflow}, {31'h0, m_ovf});
    checkOutput("ovf_req_held", {31'h0, burst_req}, 32'h1);
    checkOutput("ovf_req_addr", {8'h0, burst_addr}, {8'h0, modelAddr()});
    gnt_en = 1'b1;
    checkBursts(2, "ovf_drain");
    repeat (3) @(negedge clk);
    checkOutput("ovf_sticky", {31'h0, overflow}, 32'h1);
    pulseFrameStart();
    m_off = 0; m_ovf = 1'b0;
    @(negedge clk);
    checkOutput("ovf_cleared", {31'h0, overflow}, 32'h0);

    $display("[TB] frame_start during DATA");
    gnt_en = 1'b0; m_limit = 1'b1;
    for (int i = 0; i < 32; i++) applyStimulus(16'($urandom), 0);
    m_limit = 1'b0;
    gnt_en = 1'b1;
    waitBeats(2);
    pulseFrameStart();
    checkBursts(1, "pend");
    exp_q.delete();
    m_off = 0;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (burst_req) reqs++;
    end
    checkOutput("pend_flushed", 32'(reqs), 32'h0);
    applyStimulus(16'hBEEF, 2);
    pulseFrameStart();
    @(negedge clk);
    for (int i = 0; i < 16; i++) applyStimulus(16'($urandom), 0);
    checkBursts(1, "restart");

    $display("[TB] randomized stream");
    gnt_delay = $urandom_range(0, 3);
    rdy_mode = 2;
    for (int i = 0; i < 64; i++) applyStimulus(16'($urandom), $urandom_range(1, 3));
    checkBursts(4, "rand");
    repeat (5) @(negedge clk);
    checkOutput("rand_overflow", {31'h0, overflow}, {31'h0, m_ovf});
    checkOutput("rand_disp_buf", {31'h0, disp_buf}, {31'h0, m_disp});

    $display("[TB] reset during a burst");
    rdy_mode = 0; gnt_en = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(16'($urandom), 0);
    gnt_en = 1'b1;
    waitBeats(3);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_wr_valid", {31'h0, wr_valid}, 32'h0);
    checkOutput("mid_rst_burst_req", {31'h0, burst_req}, 32'h0);
    checkOutput("mid_rst_burst_addr", {8'h0, burst_addr}, 32'(B0));
    checkOutput("mid_rst_wr_data", wr_data, 32'h0);
    checkOutput("mid_rst_frame_done", {31'h0, frame_done}, 32'h0);
    checkOutput("mid_rst_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("mid_rst_disp_buf", {31'h0, disp_buf}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); beats_q.delete(); gnt_addr_q.delete();
    stall_seen = 1'b0;
    m_off = 0; m_sel = 1'b0; m_disp = 1'b0; m_ovf = 1'b0; m_half = 1'b0;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (burst_req || wr_valid) reqs++;
    end
    checkOutput("post_rst_quiet", 32'(reqs + beats_q.size()), 32'h0);
    for (int i = 0; i < 16; i++) applyStimulus(16'($urandom), 0);
    checkBursts(1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR0, default 0, meaning word address of frame buffer 0.
REQ-002 The block SHALL have parameter BASE_ADDR1, default 153600, meaning word address of frame buffer 1.
REQ-003 The block SHALL have parameter FRAME_WORDS, default 153600, meaning 32-bit words per frame (640x480 RGB565 / 2).
REQ-004 The block SHALL have parameter BURST_LEN, default 8, meaning words per memory burst; it is a power of two dividing FRAME_WORDS.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 16, meaning word FIFO depth; it is at least 2*BURST_LEN.
REQ-006 Ports SHALL be: clk in 1, the single clock; rst in 1, asynchronous active-high reset; frame_start in 1, one-cycle new-frame pulse; pix_valid in 1, pixel strobe; pix_data in 16, RGB565 pixel; burst_req out 1, burst request; burst_addr out 24, burst word address; burst_gnt in 1, grant; wr_valid out 1, write beat valid; wr_data out 32, write beat; wr_ready in 1, beat accept; frame_done out 1, one-cycle last-burst pulse; overflow out 1, sticky drop flag; disp_buf out 1, last completed buffer.

Function
REQ-007 Pixels SHALL be packed in pairs: first pixel of a pair to bits [15:0], second to [31:16]; the word is pushed to the FIFO on the cycle the second pixel is accepted.
REQ-008 A completed word arriving while the FIFO is full SHALL be dropped and overflow set to 1 on the next cycle.
REQ-009 The FSM SHALL have states IDLE, REQ, DATA.
REQ-010 IDLE -> REQ when FIFO count >= BURST_LEN; in REQ burst_req=1 and burst_addr holds the current address, both stable until burst_gnt.
REQ-011 REQ -> DATA on the cycle burst_gnt=1; burst_req deasserts the following cycle.
REQ-012 In DATA wr_valid=1 and wr_data=FIFO head; a beat is transferred and the FIFO popped on each cycle with wr_valid&wr_ready.
REQ-013 After BURST_LEN beats DATA -> IDLE and the address advances by BURST_LEN.
REQ-014 When the advanced offset equals FRAME_WORDS the offset SHALL wrap to 0 and frame_done pulse for one cycle coincident with the last beat.
REQ-015 Simultaneous FIFO push and pop SHALL leave count unchanged; a push at full with a simultaneous pop SHALL be accepted.
REQ-016 frame_start in IDLE SHALL, next cycle, clear the pack half, flush the FIFO, reset the offset to 0 and clear overflow.
REQ-017 frame_start in REQ or DATA SHALL set a pending flag; the current burst completes unchanged, the clear of REQ-016 applies on return to IDLE, and pixels arriving while pending are discarded.
REQ-018 An unpaired pixel at frame_start SHALL be discarded.

Reset
REQ-019 On rst: state IDLE, burst_req=0, burst_addr=BASE_ADDR0, wr_valid=0, wr_data=0, frame_done=0, overflow=0, disp_buf=0, FIFO empty, pack half 0, offset 0, pending 0.
REQ-020 rst asserted mid-burst SHALL abort the burst immediately with no further beats.

Configuration
REQ-021 With FRAME_WRITER_DOUBLE_BUF_EN defined, the base SHALL toggle between BASE_ADDR0 and BASE_ADDR1 on each frame_done and disp_buf SHALL take the just-completed buffer index.
REQ-022 Without FRAME_WRITER_DOUBLE_BUF_EN, base SHALL always be BASE_ADDR0, BASE_ADDR1 SHALL be unused and disp_buf SHALL be constant 0.

Structure
REQ-023 Shared package frame_writer_pkg SHALL hold the FSM state encoding, default FRAME_WORDS/BURST_LEN constants and the address width.
REQ-024 The FIFO SHALL be a sub-module frame_writer_fifo (synchronous, count output, first-word-fall-through).

Verification
REQ-025 16 pixels 0x0001..0x0010, burst_gnt after 2 cycles, wr_ready=1 -> one burst at address 0, beat0 0x00020001, beat7 0x0010000F, 8 consecutive beats.
REQ-026 wr_ready toggling 1/0 during a burst -> still exactly 8 beats, wr_data held on stalled cycles, no pixel loss.
REQ-027 burst_gnt withheld while 40 pixels stream -> FIFO fills at 16 words, overflow=1, words beyond the 16th dropped; frame_start in IDLE then clears overflow.
REQ-028 FRAME_WORDS=16, BURST_LEN=8, 32 pixels -> bursts at 0 and 8, frame_done with last beat; with FRAME_WRITER_DOUBLE_BUF_EN next burst at BASE_ADDR1 and disp_buf=0, else next burst at 0.
REQ-029 frame_start asserted mid-DATA -> burst completes with 8 beats, then FIFO empty, next burst at offset 0.
REQ-030 rst asserted during DATA beat 3 -> wr_valid=0 and burst_req=0 immediately, all outputs at REQ-019 values.
